// File: rtl/ahb_lite_master_arbiter_2to1.sv
// Two-master AHB-Lite input stage: a losing master's address phase is parked in a
// per-port hold register and replayed once granted; bursts are never split.
module ahb_lite_master_arbiter_2to1 #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [1:0]    HTRANS_M0_i,
    input  logic [AW-1:0] HADDR_M0_i,
    input  logic          HWRITE_M0_i,
    input  logic [2:0]    HSIZE_M0_i,
    input  logic [2:0]    HBURST_M0_i,
    input  logic [3:0]    HPROT_M0_i,
    input  logic [DW-1:0] HWDATA_M0_i,
    output logic          HREADYOUT_M0_o,
    output logic          HRESP_M0_o,
    input  logic [1:0]    HTRANS_M1_i,
    input  logic [AW-1:0] HADDR_M1_i,
    input  logic          HWRITE_M1_i,
    input  logic [2:0]    HSIZE_M1_i,
    input  logic [2:0]    HBURST_M1_i,
    input  logic [3:0]    HPROT_M1_i,
    input  logic [DW-1:0] HWDATA_M1_i,
    output logic          HREADYOUT_M1_o,
    output logic          HRESP_M1_o,
    output logic [DW-1:0] HRDATA_M_o,
    output logic [1:0]    HTRANS_o,
    output logic [AW-1:0] HADDR_o,
    output logic          HWRITE_o,
    output logic [2:0]    HSIZE_o,
    output logic [2:0]    HBURST_o,
    output logic [3:0]    HPROT_o,
    output logic [DW-1:0] HWDATA_o,
    output logic          HMASTER_o,
    input  logic          HREADY_i,
    input  logic          HRESP_i,
    input  logic [DW-1:0] HRDATA_i
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [2:0] BURST_SINGLE = 3'b000;

    logic          pend0_q, pend0_d, pend1_q, pend1_d;
    logic [1:0]    holdTrans0_q, holdTrans1_q;
    logic [AW-1:0] holdAddr0_q, holdAddr1_q;
    logic          holdWrite0_q, holdWrite1_q;
    logic [2:0]    holdSize0_q, holdSize1_q;
    logic [2:0]    holdBurst0_q, holdBurst1_q;
    logic [3:0]    holdProt0_q, holdProt1_q;

    logic          grant_q, grant_d;
    logic          lastGrant_q;
    logic          burstLock_q;
    logic          ownerValid_q, ownerPort_q;

    logic [1:0]    effTrans0, effTrans1, ownerEffTrans;
    logic [AW-1:0] effAddr0, effAddr1;
    logic          effWrite0, effWrite1;
    logic [2:0]    effSize0, effSize1, effBurst0, effBurst1;
    logic [3:0]    effProt0, effProt1;
    logic          req0, req1, grantReq, lockActive, busDrive;
    logic          capture0, capture1, issue0, issue1;

    // A port's effective address phase is its parked copy while pending, else live.
    assign effTrans0 = pend0_q ? holdTrans0_q : HTRANS_M0_i;
    assign effAddr0  = pend0_q ? holdAddr0_q  : HADDR_M0_i;
    assign effWrite0 = pend0_q ? holdWrite0_q : HWRITE_M0_i;
    assign effSize0  = pend0_q ? holdSize0_q  : HSIZE_M0_i;
    assign effBurst0 = pend0_q ? holdBurst0_q : HBURST_M0_i;
    assign effProt0  = pend0_q ? holdProt0_q  : HPROT_M0_i;
    assign effTrans1 = pend1_q ? holdTrans1_q : HTRANS_M1_i;
    assign effAddr1  = pend1_q ? holdAddr1_q  : HADDR_M1_i;
    assign effWrite1 = pend1_q ? holdWrite1_q : HWRITE_M1_i;
    assign effSize1  = pend1_q ? holdSize1_q  : HSIZE_M1_i;
    assign effBurst1 = pend1_q ? holdBurst1_q : HBURST_M1_i;
    assign effProt1  = pend1_q ? holdProt1_q  : HPROT_M1_i;

    assign req0 = pend0_q | HTRANS_M0_i[1];
    assign req1 = pend1_q | HTRANS_M1_i[1];

    // SEQ and BUSY both have bit 0 set, which is what keeps a burst owner locked.
    assign ownerEffTrans = grant_q ? effTrans1 : effTrans0;
    assign lockActive    = burstLock_q & ownerEffTrans[0];

    always_comb begin
        grant_d = grant_q;
        if (HREADY_i && !lockActive) begin
            if (req0 && !req1) begin
                grant_d = 1'b0;
            end else if (req1 && !req0) begin
                grant_d = 1'b1;
            end else if (req0 && req1) begin
                grant_d = (FIXED_PRIO != 0) ? 1'b0 : ~lastGrant_q;
            end
        end
    end

    assign grantReq = grant_d ? req1 : req0;
    assign busDrive = HRESETn & (grantReq | lockActive);

    always_comb begin
        HTRANS_o = TRANS_IDLE;
        HADDR_o  = '0;
        HWRITE_o = 1'b0;
        HSIZE_o  = 3'b000;
        HBURST_o = BURST_SINGLE;
        HPROT_o  = 4'b0000;
        if (busDrive) begin
            if (grant_d) begin
                HTRANS_o = effTrans1;
                HADDR_o  = effAddr1;
                HWRITE_o = effWrite1;
                HSIZE_o  = effSize1;
                HBURST_o = effBurst1;
                HPROT_o  = effProt1;
            end else begin
                HTRANS_o = effTrans0;
                HADDR_o  = effAddr0;
                HWRITE_o = effWrite0;
                HSIZE_o  = effSize0;
                HBURST_o = effBurst0;
                HPROT_o  = effProt0;
            end
        end
    end

    assign HMASTER_o  = grant_d;
    assign HRDATA_M_o = HRDATA_i;
    assign HWDATA_o   = !ownerValid_q ? '0 : (ownerPort_q ? HWDATA_M1_i : HWDATA_M0_i);

    always_comb begin
        HREADYOUT_M0_o = 1'b1;
        HRESP_M0_o     = 1'b0;
        HREADYOUT_M1_o = 1'b1;
        HRESP_M1_o     = 1'b0;
        if (ownerValid_q && !ownerPort_q) begin
            HREADYOUT_M0_o = HREADY_i;
            HRESP_M0_o     = HRESP_i;
        end else if (pend0_q) begin
            HREADYOUT_M0_o = 1'b0;
        end
        if (ownerValid_q && ownerPort_q) begin
            HREADYOUT_M1_o = HREADY_i;
            HRESP_M1_o     = HRESP_i;
        end else if (pend1_q) begin
            HREADYOUT_M1_o = 1'b0;
        end
    end

    // A transfer that is granted on a ready bus goes straight out and is never parked.
    assign capture0 = HTRANS_M0_i[1] & HREADYOUT_M0_o & ~(HREADY_i & ~grant_d);
    assign capture1 = HTRANS_M1_i[1] & HREADYOUT_M1_o & ~(HREADY_i &  grant_d);
    assign issue0   = HREADY_i & ~grant_d & pend0_q;
    assign issue1   = HREADY_i &  grant_d & pend1_q;
    assign pend0_d  = capture0 | (pend0_q & ~issue0);
    assign pend1_d  = capture1 | (pend1_q & ~issue1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend0_q      <= 1'b0;
            holdTrans0_q <= TRANS_IDLE;
            holdAddr0_q  <= '0;
            holdWrite0_q <= 1'b0;
            holdSize0_q  <= 3'b000;
            holdBurst0_q <= BURST_SINGLE;
            holdProt0_q  <= 4'b0000;
        end else begin
            pend0_q <= pend0_d;
            if (capture0) begin
                holdTrans0_q <= HTRANS_M0_i;
                holdAddr0_q  <= HADDR_M0_i;
                holdWrite0_q <= HWRITE_M0_i;
                holdSize0_q  <= HSIZE_M0_i;
                holdBurst0_q <= HBURST_M0_i;
                holdProt0_q  <= HPROT_M0_i;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend1_q      <= 1'b0;
            holdTrans1_q <= TRANS_IDLE;
            holdAddr1_q  <= '0;
            holdWrite1_q <= 1'b0;
            holdSize1_q  <= 3'b000;
            holdBurst1_q <= BURST_SINGLE;
            holdProt1_q  <= 4'b0000;
        end else begin
            pend1_q <= pend1_d;
            if (capture1) begin
                holdTrans1_q <= HTRANS_M1_i;
                holdAddr1_q  <= HADDR_M1_i;
                holdWrite1_q <= HWRITE_M1_i;
                holdSize1_q  <= HSIZE_M1_i;
                holdBurst1_q <= HBURST_M1_i;
                holdProt1_q  <= HPROT_M1_i;
            end
        end
    end

    // lastGrant starts at M1 so that M0 takes the first tie after reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q      <= 1'b0;
            lastGrant_q  <= 1'b1;
            burstLock_q  <= 1'b0;
            ownerValid_q <= 1'b0;
            ownerPort_q  <= 1'b0;
        end else if (HREADY_i) begin
            grant_q      <= grant_d;
            ownerValid_q <= HTRANS_o[1];
            ownerPort_q  <= grant_d;
            if (HTRANS_o[1]) begin
                lastGrant_q <= grant_d;
                burstLock_q <= (HBURST_o != BURST_SINGLE);
            end else if (HTRANS_o == TRANS_IDLE) begin
                burstLock_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_arbiter_2to1.sv
// Scoreboard bench for the two-master AHB-Lite arbiter: each directed cycle queues
// the bus/port values it expects, and a negedge monitor retires them.
module tb_ahb_lite_master_arbiter_2to1;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NSEQ   = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [31:0] WDATA0 = 32'hD0D0_1234;
    localparam logic [31:0] WDATA1 = 32'h1111_BEEF;

    localparam int SIG_HTRANS  = 0;
    localparam int SIG_HADDR   = 1;
    localparam int SIG_HMASTER = 2;
    localparam int SIG_HWRITE  = 3;
    localparam int SIG_HBURST  = 4;
    localparam int SIG_HWDATA  = 5;
    localparam int SIG_RDY0    = 6;
    localparam int SIG_RDY1    = 7;
    localparam int SIG_RESP0   = 8;
    localparam int SIG_RESP1   = 9;
    localparam int SIG_HRDATAM = 10;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  htransM0, htransM1;
    logic [31:0] haddrM0, haddrM1, hwdataM0, hwdataM1;
    logic        hwriteM0, hwriteM1;
    logic [2:0]  hburstM0, hburstM1;
    logic        hreadyoutM0, hreadyoutM1, hrespM0, hrespM1;
    logic [31:0] hrdataM, haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hmaster, hready, hresp;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] value;
        int          due;
    } expect_t;

    expect_t sbQueue[$];
    expect_t keepQueue[$];
    int cycleCount = 0;
    int checkCount = 0;
    int errorCount = 0;

    ahb_lite_master_arbiter_2to1 dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .HTRANS_M0_i    (htransM0),
        .HADDR_M0_i     (haddrM0),
        .HWRITE_M0_i    (hwriteM0),
        .HSIZE_M0_i     (3'b010),
        .HBURST_M0_i    (hburstM0),
        .HPROT_M0_i     (4'b0011),
        .HWDATA_M0_i    (hwdataM0),
        .HREADYOUT_M0_o (hreadyoutM0),
        .HRESP_M0_o     (hrespM0),
        .HTRANS_M1_i    (htransM1),
        .HADDR_M1_i     (haddrM1),
        .HWRITE_M1_i    (hwriteM1),
        .HSIZE_M1_i     (3'b010),
        .HBURST_M1_i    (hburstM1),
        .HPROT_M1_i     (4'b0011),
        .HWDATA_M1_i    (hwdataM1),
        .HREADYOUT_M1_o (hreadyoutM1),
        .HRESP_M1_o     (hrespM1),
        .HRDATA_M_o     (hrdataM),
        .HTRANS_o       (htrans),
        .HADDR_o        (haddr),
        .HWRITE_o       (hwrite),
        .HSIZE_o        (hsize),
        .HBURST_o       (hburst),
        .HPROT_o        (hprot),
        .HWDATA_o       (hwdata),
        .HMASTER_o      (hmaster),
        .HREADY_i       (hready),
        .HRESP_i        (hresp),
        .HRDATA_i       (hrdata)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, wanted %h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] sampleSignal(input int sig);
        case (sig)
            SIG_HTRANS:  return {30'd0, htrans};
            SIG_HADDR:   return haddr;
            SIG_HMASTER: return {31'd0, hmaster};
            SIG_HWRITE:  return {31'd0, hwrite};
            SIG_HBURST:  return {29'd0, hburst};
            SIG_HWDATA:  return hwdata;
            SIG_RDY0:    return {31'd0, hreadyoutM0};
            SIG_RDY1:    return {31'd0, hreadyoutM1};
            SIG_RESP0:   return {31'd0, hrespM0};
            SIG_RESP1:   return {31'd0, hrespM1};
            SIG_HRDATAM: return hrdataM;
            default:     return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Retire every expectation due this cycle; later ones stay queued.
    always @(negedge HCLK) begin
        keepQueue = {};
        foreach (sbQueue[i]) begin
            if (sbQueue[i].due == cycleCount)
                checkOutput(sbQueue[i].tag, sampleSignal(sbQueue[i].sig), sbQueue[i].value);
            else
                keepQueue.push_back(sbQueue[i]);
        end
        sbQueue = keepQueue;
    end

    task automatic expectSig(input string tag, input int sig, input logic [31:0] value, input int delay = 0);
        expect_t item;
        item.tag   = tag;
        item.sig   = sig;
        item.value = value;
        item.due   = cycleCount + delay;
        sbQueue.push_back(item);
    endtask

    task automatic applyStimulus(input logic rstN,
                                 input logic [1:0] t0, input logic [31:0] a0, input logic w0, input logic [2:0] b0,
                                 input logic [1:0] t1, input logic [31:0] a1, input logic w1, input logic [2:0] b1,
                                 input logic rdy, input logic resp);
        @(posedge HCLK);
        #1;
        HRESETn  = rstN;
        htransM0 = t0;
        haddrM0  = a0;
        hwriteM0 = w0;
        hburstM0 = b0;
        htransM1 = t1;
        haddrM1  = a1;
        hwriteM1 = w1;
        hburstM1 = b1;
        hready   = rdy;
        hresp    = resp;
        hrdata   = 32'hA5A5_0000 + 32'(cycleCount);
    endtask

    task automatic idleCycle(input logic rdy, input logic resp);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, rdy, resp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        htransM0 = IDLE; haddrM0 = '0; hwriteM0 = 1'b0; hburstM0 = SINGLE; hwdataM0 = WDATA0;
        htransM1 = IDLE; haddrM1 = '0; hwriteM1 = 1'b0; hburstM1 = SINGLE; hwdataM1 = WDATA1;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;

        // reset state
        applyStimulus(1'b0, IDLE, 32'h0, 1'b0, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("rstHtrans", SIG_HTRANS, 32'd0);
        expectSig("rstHaddr", SIG_HADDR, 32'd0);
        expectSig("rstHmaster", SIG_HMASTER, 32'd0);
        expectSig("rstRdy0", SIG_RDY0, 32'd1);
        expectSig("rstRdy1", SIG_RDY1, 32'd1);
        expectSig("rstResp0", SIG_RESP0, 32'd0);
        expectSig("rstHwdata", SIG_HWDATA, 32'd0);
        idleCycle(1'b1, 1'b0);

        // both masters NONSEQ together: M0 first, M1 parked
        applyStimulus(1'b1, NSEQ, 32'h100, 1'b0, SINGLE, NSEQ, 32'h2000_0000, 1'b1, SINGLE, 1'b1, 1'b0);
        expectSig("tieHaddr", SIG_HADDR, 32'h100);
        expectSig("tieHmaster", SIG_HMASTER, 32'd0);
        expectSig("tieHtrans", SIG_HTRANS, 32'd2);
        expectSig("tieRdy1", SIG_RDY1, 32'd1);
        applyStimulus(1'b1, NSEQ, 32'h104, 1'b0, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("heldM1Haddr", SIG_HADDR, 32'h2000_0000);
        expectSig("heldM1Hmaster", SIG_HMASTER, 32'd1);
        expectSig("heldM1Hwrite", SIG_HWRITE, 32'd1);
        expectSig("heldM1Rdy1", SIG_RDY1, 32'd0);
        expectSig("heldM1Rdy0", SIG_RDY0, 32'd1);
        applyStimulus(1'b1, NSEQ, 32'h104, 1'b0, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("rrM0Haddr", SIG_HADDR, 32'h104);
        expectSig("rrM0Hmaster", SIG_HMASTER, 32'd0);
        expectSig("rrM0Rdy0", SIG_RDY0, 32'd0);
        expectSig("rrM1Rdy1", SIG_RDY1, 32'd1);
        expectSig("rrM1Hwdata", SIG_HWDATA, WDATA1);
        idleCycle(1'b1, 1'b0);
        expectSig("rrIdleHtrans", SIG_HTRANS, 32'd0);
        expectSig("rrIdleRdy0", SIG_RDY0, 32'd1);

        // M0 alone, zero-wait read
        applyStimulus(1'b1, NSEQ, 32'h10, 1'b0, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("soloHtrans", SIG_HTRANS, 32'd2);
        expectSig("soloHaddr", SIG_HADDR, 32'h10);
        expectSig("soloHmaster", SIG_HMASTER, 32'd0);
        expectSig("soloRdy0", SIG_RDY0, 32'd1);
        expectSig("soloHrdata", SIG_HRDATAM, 32'hA5A5_0000 + 32'(cycleCount + 1), 1);
        idleCycle(1'b1, 1'b0);
        expectSig("soloDataRdy0", SIG_RDY0, 32'd1);

        // M1 INCR4 burst, M0 arrives at beat 2 and waits for the burst to finish
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h3000, 1'b0, INCR4, 1'b1, 1'b0);
        expectSig("burstB1Hmaster", SIG_HMASTER, 32'd1);
        expectSig("burstB1Hburst", SIG_HBURST, 32'd3);
        applyStimulus(1'b1, NSEQ, 32'h40, 1'b0, SINGLE, SEQ, 32'h3004, 1'b0, INCR4, 1'b1, 1'b0);
        expectSig("burstB2Haddr", SIG_HADDR, 32'h3004);
        expectSig("burstB2Hmaster", SIG_HMASTER, 32'd1);
        expectSig("burstB2Rdy0", SIG_RDY0, 32'd1);
        applyStimulus(1'b1, NSEQ, 32'h40, 1'b0, SINGLE, SEQ, 32'h3008, 1'b0, INCR4, 1'b1, 1'b0);
        expectSig("burstB3Haddr", SIG_HADDR, 32'h3008);
        expectSig("burstB3Rdy0", SIG_RDY0, 32'd0);
        applyStimulus(1'b1, NSEQ, 32'h40, 1'b0, SINGLE, SEQ, 32'h300C, 1'b0, INCR4, 1'b1, 1'b0);
        expectSig("burstB4Haddr", SIG_HADDR, 32'h300C);
        expectSig("burstB4Hmaster", SIG_HMASTER, 32'd1);
        applyStimulus(1'b1, NSEQ, 32'h40, 1'b0, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("afterBurstHaddr", SIG_HADDR, 32'h40);
        expectSig("afterBurstHmaster", SIG_HMASTER, 32'd0);
        expectSig("afterBurstHburst", SIG_HBURST, 32'd0);
        expectSig("afterBurstRdy0", SIG_RDY0, 32'd0);
        expectSig("afterBurstRdy1", SIG_RDY1, 32'd1);
        idleCycle(1'b1, 1'b0);
        expectSig("afterBurstDataRdy0", SIG_RDY0, 32'd1);

        // M0 write with two slave wait states, M1 arrives during the stall
        applyStimulus(1'b1, NSEQ, 32'h50, 1'b1, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("waitAddrHaddr", SIG_HADDR, 32'h50);
        expectSig("waitAddrHwrite", SIG_HWRITE, 32'd1);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h2000_0100, 1'b0, SINGLE, 1'b0, 1'b0);
        expectSig("wait1Htrans", SIG_HTRANS, 32'd0);
        expectSig("wait1Hmaster", SIG_HMASTER, 32'd0);
        expectSig("wait1Hwdata", SIG_HWDATA, WDATA0);
        expectSig("wait1Rdy0", SIG_RDY0, 32'd0);
        expectSig("wait1Rdy1", SIG_RDY1, 32'd1);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h2000_0100, 1'b0, SINGLE, 1'b0, 1'b0);
        expectSig("wait2Htrans", SIG_HTRANS, 32'd0);
        expectSig("wait2Hwdata", SIG_HWDATA, WDATA0);
        expectSig("wait2Rdy1", SIG_RDY1, 32'd0);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h2000_0100, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("waitDoneHaddr", SIG_HADDR, 32'h2000_0100);
        expectSig("waitDoneHmaster", SIG_HMASTER, 32'd1);
        expectSig("waitDoneRdy0", SIG_RDY0, 32'd1);
        expectSig("waitDoneRdy1", SIG_RDY1, 32'd0);
        expectSig("waitDoneHwdata", SIG_HWDATA, WDATA0);
        idleCycle(1'b1, 1'b0);
        expectSig("waitTailRdy1", SIG_RDY1, 32'd1);

        // two-cycle ERROR response to M1
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h2000_0200, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("errAddrHmaster", SIG_HMASTER, 32'd1);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h2000_0204, 1'b0, SINGLE, 1'b0, 1'b1);
        expectSig("err1Resp1", SIG_RESP1, 32'd1);
        expectSig("err1Rdy1", SIG_RDY1, 32'd0);
        expectSig("err1Rdy0", SIG_RDY0, 32'd1);
        expectSig("err1Resp0", SIG_RESP0, 32'd0);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, IDLE, 32'h0, 1'b0, SINGLE, 1'b1, 1'b1);
        expectSig("err2Resp1", SIG_RESP1, 32'd1);
        expectSig("err2Rdy1", SIG_RDY1, 32'd1);
        expectSig("err2Resp0", SIG_RESP0, 32'd0);
        expectSig("err2Htrans", SIG_HTRANS, 32'd0);
        idleCycle(1'b1, 1'b0);
        expectSig("errTailResp1", SIG_RESP1, 32'd0);
        expectSig("errTailHtrans", SIG_HTRANS, 32'd0);

        // reset while M1 is parked, then a tie right after release
        applyStimulus(1'b1, NSEQ, 32'h60, 1'b0, SINGLE, NSEQ, 32'h2000_0300, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("prerstHaddr", SIG_HADDR, 32'h60);
        expectSig("prerstHmaster", SIG_HMASTER, 32'd0);
        applyStimulus(1'b0, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h2000_0300, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("midrstHtrans", SIG_HTRANS, 32'd0);
        expectSig("midrstHaddr", SIG_HADDR, 32'd0);
        expectSig("midrstRdy0", SIG_RDY0, 32'd1);
        expectSig("midrstRdy1", SIG_RDY1, 32'd1);
        applyStimulus(1'b1, NSEQ, 32'h70, 1'b0, SINGLE, NSEQ, 32'h2000_0400, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("postrstHmaster", SIG_HMASTER, 32'd0);
        expectSig("postrstHaddr", SIG_HADDR, 32'h70);
        expectSig("postrstRdy1", SIG_RDY1, 32'd1);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, SINGLE, NSEQ, 32'h2000_0400, 1'b0, SINGLE, 1'b1, 1'b0);
        expectSig("postrstM1Haddr", SIG_HADDR, 32'h2000_0400);
        expectSig("postrstM1Hmaster", SIG_HMASTER, 32'd1);
        expectSig("postrstM1Rdy1", SIG_RDY1, 32'd0);
        idleCycle(1'b1, 1'b0);
        expectSig("finalHtrans", SIG_HTRANS, 32'd0);
        expectSig("finalRdy1", SIG_RDY1, 32'd1);
        idleCycle(1'b1, 1'b0);

        @(posedge HCLK);
        #1;
        checkOutput("scoreboardDrain", 32'(sbQueue.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
